// File: rtl/cosine_job_sequencer.sv
// cosine_job_sequencer: collects 8-byte jobs, drives the cosine engine through reset/start/done, returns the result.
module cosine_job_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int JOB_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 eng_reset,
  output logic                 eng_start,
  output logic [31:0]          eng_a_vec,
  output logic [31:0]          eng_b_vec,
  input  logic                 eng_done,
  input  logic [15:0]          eng_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_data,
  output logic                 res_timeout,
  output logic                 frame_err,
  output logic [JOB_CNT_W-1:0] job_count,
  output logic                 busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, ARM, START, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, wr_idx;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] res_data_q, res_data_d;
  logic [JOB_CNT_W-1:0] job_count_q, job_count_d;
  logic res_timeout_q, res_timeout_d, frame_err_q, frame_err_d;
  logic eng_reset_q, eng_reset_d, eng_start_q, eng_start_d;
  logic res_valid_q, res_valid_d, busy_q, busy_d;
  logic acc;
  assign in_ready = (state_q == IDLE) && !reset;
  assign acc = in_valid && in_ready;
  assign wr_idx = in_sof ? 3'd0 : idx_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      frame_err_q   <= 1'b0;
      job_count_q   <= '0;
      eng_reset_q   <= 1'b0;
      eng_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      frame_err_q   <= frame_err_d;
      job_count_q   <= job_count_d;
      eng_reset_q   <= eng_reset_d;
      eng_start_q   <= eng_start_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end
  // A framing error is an sof that does not land on index 0, or a non-sof byte that does.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    job_count_d   = job_count_q;
    frame_err_d   = frame_err_q | (acc && (in_sof ^ (idx_q == 3'd0)));
    case (state_q)
      IDLE: if (acc && (in_sof || idx_q != 3'd0)) begin
        if (wr_idx[2]) b_d[{wr_idx[1:0], 3'b000} +: 8] = in_data;
        else a_d[{wr_idx[1:0], 3'b000} +: 8] = in_data;
        idx_d = wr_idx + 3'd1;
        state_d = (wr_idx == 3'd7) ? ARM : IDLE;
      end
      ARM: state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (eng_done || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          res_data_d = eng_done ? eng_result : 16'h0000;
          res_timeout_d = !eng_done;
        end
      end
      RESP: if (res_ready) begin
        state_d = IDLE;
        idx_d = '0;
        job_count_d = job_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    eng_reset_d = (state_d == ARM) || (state_d == START) || (state_d == WAIT);
    eng_start_d = state_d == START;
    res_valid_d = state_d == RESP;
    busy_d      = state_d != IDLE;
  end
  assign eng_reset   = eng_reset_q;
  assign eng_start   = eng_start_q;
  assign eng_a_vec   = a_q;
  assign eng_b_vec   = b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign frame_err   = frame_err_q;
  assign job_count   = job_count_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_cosine_job_sequencer.sv
// tb_cosine_job_sequencer: directed scenarios against a sticky-done engine stub.
module tb_cosine_job_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, res_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, eng_reset, eng_start, res_valid, res_timeout, frame_err, busy;
  logic [31:0] eng_a_vec, eng_b_vec;
  logic [15:0] res_data;
  logic [7:0] job_count;
  logic eng_done = 1'b0;
  logic [15:0] eng_result;
  logic [15:0] stub_result = 16'h0007;
  int stub_delay = 25;
  logic stub_never = 1'b0;
  logic stub_run = 1'b0;
  int stub_cnt = 0;
  int errors = 0;
  int checks = 0;
  int n;
  cosine_job_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready), .eng_reset(eng_reset), .eng_start(eng_start), .eng_a_vec(eng_a_vec),
    .eng_b_vec(eng_b_vec), .eng_done(eng_done), .eng_result(eng_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout), .frame_err(frame_err),
    .job_count(job_count), .busy(busy)
  );
  always #5 clk = ~clk;
  assign eng_result = stub_result;
  // Engine model: done is sticky and only cleared while eng_reset is low.
  always @(posedge clk) begin
    if (eng_reset !== 1'b1) begin
      stub_run <= 1'b0;
      stub_cnt <= 0;
      eng_done <= 1'b0;
    end else begin
      if (eng_start) stub_run <= 1'b1;
      if (stub_run && !stub_never) begin
        stub_cnt <= stub_cnt + 1;
        if (stub_cnt == stub_delay - 1) eng_done <= 1'b1;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_sof = s;
    in_data = d;
    tick();
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask
  task automatic send_job(input logic [7:0] base);
    send(base + 8'd1, 1'b1);
    for (int i = 2; i <= 8; i++) send(base + 8'(i), 1'b0);
  endtask
  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_res_valid: res_valid=%b after %0d cycles, required 1", res_valid, limit);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, eng_reset, eng_start, res_valid, res_timeout, frame_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000",
               {in_ready, eng_reset, eng_start, res_valid, res_timeout, frame_err, busy});
    end
    checks++;
    if ({eng_a_vec, eng_b_vec, res_data, job_count} !== 88'h0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h res=%h cnt=%h required all 0", eng_a_vec, eng_b_vec, res_data, job_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", in_ready);
    end
  endtask
  task automatic test_single;
    stub_result = 16'h0007;
    send_job(8'h00);
    checks++;
    if (eng_a_vec !== 32'h04030201 || eng_b_vec !== 32'h08070605) begin
      errors++;
      $display("FAIL single_vectors: a=%h b=%h required 04030201 08070605", eng_a_vec, eng_b_vec);
    end
    checks++;
    if (eng_start !== 1'b0 || eng_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_arm: start=%b rst=%b busy=%b required 0 1 1", eng_start, eng_reset, busy);
    end
    tick();
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start: got %b required 1", eng_start);
    end
    tick();
    checks++;
    if (eng_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_pulse: got %b required 0", eng_start);
    end
    wait_valid(60, n);
    checks++;
    if (res_data !== 16'h0007 || res_timeout !== 1'b0 || eng_reset !== 1'b0 || job_count !== 8'd0) begin
      errors++;
      $display("FAIL single_resp: data=%h to=%b rst=%b cnt=%0d required 0007 0 0 0", res_data, res_timeout, eng_reset, job_count);
    end
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0007) begin
      errors++;
      $display("FAIL single_hold: valid=%b data=%h required 1 0007", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || job_count !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b cnt=%0d busy=%b required 0 1 0", res_valid, job_count, busy);
    end
  endtask
  task automatic test_back_to_back;
    res_ready = 1'b1;
    stub_result = 16'h0042;
    send_job(8'h20);
    checks++;
    if (eng_a_vec !== 32'h24232221 || eng_b_vec !== 32'h28272625) begin
      errors++;
      $display("FAIL b2b_vectors: a=%h b=%h required 24232221 28272625", eng_a_vec, eng_b_vec);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sof = 1'b1;
      in_data = 8'hFF;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_in_wait: got %b required 0", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    checks++;
    if (eng_a_vec !== 32'h24232221 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frozen: a=%h ferr=%b required 24232221 0", eng_a_vec, frame_err);
    end
    wait_valid(60, n);
    checks++;
    if (res_data !== 16'h0042 || eng_reset !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp: data=%h rst=%b required 0042 0", res_data, eng_reset);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || job_count !== 8'd2 || eng_reset !== 1'b0) begin
      errors++;
      $display("FAIL b2b_one_cycle: valid=%b cnt=%0d rst=%b required 0 2 0", res_valid, job_count, eng_reset);
    end
    stub_result = 16'h0055;
    send_job(8'h30);
    checks++;
    if (eng_a_vec !== 32'h34333231 || eng_b_vec !== 32'h38373635) begin
      errors++;
      $display("FAIL b2b_vectors2: a=%h b=%h required 34333231 38373635", eng_a_vec, eng_b_vec);
    end
    wait_valid(60, n);
    checks++;
    if (res_data !== 16'h0055) begin
      errors++;
      $display("FAIL b2b_resp2: data=%h required 0055", res_data);
    end
    tick();
    res_ready = 1'b0;
    checks++;
    if (job_count !== 8'd3 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d valid=%b required 3 0", job_count, res_valid);
    end
  endtask
  task automatic test_timeout;
    stub_never = 1'b1;
    send_job(8'h60);
    tick();
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start: got %b required 1", eng_start);
    end
    // 64 WAIT cycles follow START, then RESP.
    wait_valid(100, n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL to_latency: got %0d cycles required 65", n);
    end
    checks++;
    if (res_data !== 16'h0000 || res_timeout !== 1'b1 || eng_reset !== 1'b0) begin
      errors++;
      $display("FAIL to_resp: data=%h to=%b rst=%b required 0000 1 0", res_data, res_timeout, eng_reset);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    stub_never = 1'b0;
    checks++;
    if (job_count !== 8'd4) begin
      errors++;
      $display("FAIL to_count: got %0d required 4", job_count);
    end
  endtask
  task automatic test_backpressure;
    logic bad;
    stub_delay = 10;
    stub_result = 16'hBEEF;
    send_job(8'h70);
    wait_valid(60, n);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_data !== 16'hBEEF || res_timeout !== 1'b0 || job_count !== 8'd4) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable: unstable during backpressure, last valid=%b data=%h cnt=%0d required 1 beef 4", res_valid, res_data, job_count);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    checks++;
    if (job_count !== 8'd5 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: cnt=%0d valid=%b required 5 0", job_count, res_valid);
    end
    stub_delay = 25;
  endtask
  task automatic test_framing;
    stub_result = 16'h1234;
    send(8'hAA, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_drop: ferr=%b busy=%b required 1 0", frame_err, busy);
    end
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send_job(8'h10);
    checks++;
    if (eng_a_vec !== 32'h14131211 || eng_b_vec !== 32'h18171615 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_vectors: a=%h b=%h ferr=%b required 14131211 18171615 1", eng_a_vec, eng_b_vec, frame_err);
    end
    wait_valid(60, n);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (job_count !== 8'd6 || res_data !== 16'h1234) begin
      errors++;
      $display("FAIL frame_job: cnt=%0d data=%h required 6 1234", job_count, res_data);
    end
  endtask
  task automatic test_reset_wait;
    logic seen;
    stub_result = 16'h0099;
    send_job(8'h40);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, eng_reset, eng_start, res_valid, res_timeout, frame_err, busy} !== 7'b0 ||
        {eng_a_vec, eng_b_vec, res_data, job_count} !== 88'h0) begin
      errors++;
      $display("FAIL rst_wait_outputs: flags=%b a=%h b=%h res=%h cnt=%h required all 0",
               {in_ready, eng_reset, eng_start, res_valid, res_timeout, frame_err, busy}, eng_a_vec, eng_b_vec, res_data, job_count);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_quiet: result or busy seen after abort, got 1 required 0");
    end
    send_job(8'h50);
    checks++;
    if (eng_a_vec !== 32'h54535251 || eng_b_vec !== 32'h58575655) begin
      errors++;
      $display("FAIL rst_wait_vectors: a=%h b=%h required 54535251 58575655", eng_a_vec, eng_b_vec);
    end
    wait_valid(60, n);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (job_count !== 8'd1 || res_data !== 16'h0099 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_next: cnt=%0d data=%h to=%b required 1 0099 0", job_count, res_data, res_timeout);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_framing();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
